fetch_queue: RTL and testbench

- Decoupling instruction buffer between the fetch unit and decode; it is the consumer end of the fetch interface.
- Captures the fetch unit's pc/instr/pc+4 each cycle it asserts fetch_en.
- Presents the oldest entry to decode through a valid/ready handshake.
- Stalls fetch when full; discards all buffered wrong-path words on a redirect.

---
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO: captures fetch words, presents the oldest to decode.
// Optional macro FETCHQ_PERF_EN adds perf_full_cycles / perf_flushes counters.
module fetch_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    input  logic [DATA_WIDTH-1:0] if_instr,
    input  logic [ADDR_WIDTH-1:0] if_pc_plus4,
    output logic                  fetch_en,
    input  logic                  redirect_taken,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0] id_pc_plus4
`ifdef FETCHQ_PERF_EN
    ,
    output logic [31:0]           perf_full_cycles,
    output logic [31:0]           perf_flushes
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_pc    [DEPTH];
    logic [DATA_WIDTH-1:0] r_instr [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc4   [DEPTH];

    logic             w_full;
    logic             w_enq;
    logic             w_deq;
    logic [DEPTH-1:0] w_wr_sel;

    // Full blocks capture even if decode drains the head this cycle (no bypass).
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign fetch_en = !w_full || redirect_taken;
    assign id_valid = (r_count != '0);
    assign w_enq    = !w_full && !redirect_taken;
    assign w_deq    = id_valid && id_ready && !redirect_taken;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign w_wr_sel[gi] = w_enq && (r_wr_ptr == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
                r_pc4[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_sel[i]) begin
                    r_pc[i]    <= if_pc;
                    r_instr[i] <= if_instr;
                    r_pc4[i]   <= if_pc_plus4;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect_taken) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign id_pc       = r_pc[r_rd_ptr];
    assign id_instr    = r_instr[r_rd_ptr];
    assign id_pc_plus4 = r_pc4[r_rd_ptr];

`ifdef FETCHQ_PERF_EN
    logic [31:0] r_full_cycles;
    logic [31:0] r_flushes;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full_cycles <= '0;
            r_flushes     <= '0;
        end else begin
            if (w_full && !redirect_taken) r_full_cycles <= r_full_cycles + 1'b1;
            if (redirect_taken)            r_flushes     <= r_flushes + 1'b1;
        end
    end

    assign perf_full_cycles = r_full_cycles;
    assign perf_flushes     = r_flushes;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a fetch-unit model pushes captured words,
// decode handshakes pop and compare against the head.
module tb_fetch_queue;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] if_pc;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc_plus4;
    logic          fetch_en;
    logic          redirect_taken;
    logic          id_valid;
    logic          id_ready;
    logic [AW-1:0] id_pc;
    logic [DW-1:0] id_instr;
    logic [AW-1:0] id_pc_plus4;
`ifdef FETCHQ_PERF_EN
    logic [31:0]   perf_full_cycles;
    logic [31:0]   perf_flushes;
    int unsigned   exp_full_cycles;
    int unsigned   exp_flushes;
`endif

    fetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_pc_plus4    (if_pc_plus4),
        .fetch_en       (fetch_en),
        .redirect_taken (redirect_taken),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_pc_plus4    (id_pc_plus4)
`ifdef FETCHQ_PERF_EN
        ,
        .perf_full_cycles (perf_full_cycles),
        .perf_flushes     (perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
        logic [AW-1:0] pc4;
    } entry_t;

    entry_t        sb_q[$];
    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] redir_target;
    int            n_checks = 0;
    int            n_pass   = 0;

    function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] pc);
        return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_fetch();
        if_pc       = fetch_pc;
        if_instr    = instr_of(fetch_pc);
        if_pc_plus4 = fetch_pc + 32'd4;
    endtask

    // One clock: check outputs at negedge against the model, then advance model at posedge.
    task automatic step();
        bit     exp_valid, exp_fe, enq, deq;
        entry_t head;
        drive_fetch();
        @(negedge clk);
        if (!rst) begin
            exp_valid = (sb_q.size() != 0);
            exp_fe    = (sb_q.size() != DEPTH) || redirect_taken;
            check("id_valid", 64'(id_valid), 64'(exp_valid));
            check("fetch_en", 64'(fetch_en), 64'(exp_fe));
            if (exp_valid) begin
                head = sb_q[0];
                check("id_pc", 64'(id_pc), 64'(head.pc));
                check("id_instr", 64'(id_instr), 64'(head.instr));
                check("id_pc_plus4", 64'(id_pc_plus4), 64'(head.pc4));
            end
            enq = exp_fe && !redirect_taken;
            deq = exp_valid && id_ready && !redirect_taken;
            $display("cyc pc=%h redir=%0d rdy=%0d enq=%0d deq=%0d depth=%0d",
                     if_pc, redirect_taken, id_ready, enq, deq, sb_q.size());
        end
        @(posedge clk);
        if (rst) begin
            sb_q.delete();
`ifdef FETCHQ_PERF_EN
            exp_full_cycles = 0;
            exp_flushes     = 0;
`endif
        end else begin
`ifdef FETCHQ_PERF_EN
            if (sb_q.size() == DEPTH && !redirect_taken) exp_full_cycles++;
            if (redirect_taken) exp_flushes++;
`endif
            if (redirect_taken) begin
                sb_q.delete();
                fetch_pc = redir_target;
            end else begin
                if (deq) void'(sb_q.pop_front());
                if (enq) begin
                    sb_q.push_back({fetch_pc, instr_of(fetch_pc), fetch_pc + 32'd4});
                    fetch_pc = fetch_pc + 32'd4;
                end
            end
        end
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_taken = 1'b0;
        id_ready       = 1'b0;
        fetch_pc       = '0;
        redir_target   = '0;
        step();
        step();
        // Reset state, sampled while reset is still asserted
        @(negedge clk);
        check("rst_valid", 64'(id_valid), 64'd0);
        check("rst_fetch_en", 64'(fetch_en), 64'd1);
        check("rst_id_pc", 64'(id_pc), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fill with decode stalled: four captures, then fetch stalls on 0x10
        for (int i = 0; i < 6; i++) step();
        @(negedge clk);
        check("full_fetch_en", 64'(fetch_en), 64'd0);
        check("full_head_pc", 64'(id_pc), 64'h0);
        @(posedge clk); #1;

        // Drain: head sequence 0,4,8,C then 0x10 refilled behind
        id_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Redirect with three entries buffered
        id_ready = 1'b0;
        while (sb_q.size() < 3) step();
        redirect_taken = 1'b1;
        redir_target   = 32'h100;
        step();
        redirect_taken = 1'b0;
        step();
        step();
        check("redir_head_pc", 64'(id_pc), 64'h100);

        // Back-to-back redirects
        redirect_taken = 1'b1;
        redir_target   = 32'h200;
        step();
        redir_target   = 32'h300;
        step();
        redirect_taken = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Random traffic: ready and occasional redirects
        for (int i = 0; i < 120; i++) begin
            id_ready       = ($urandom_range(0, 2) != 0);
            redirect_taken = ($urandom_range(0, 11) == 0);
            redir_target   = {$urandom_range(0, 16'hFFFF), 2'b00};
            step();
        end
        redirect_taken = 1'b0;

`ifdef FETCHQ_PERF_EN
        // Fresh counters: hold full five cycles, then two redirects
        rst = 1'b1; step(); rst = 1'b0;
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 5; i++) step();
        redirect_taken = 1'b1;
        step(); step();
        redirect_taken = 1'b0;
        @(negedge clk);
        check("perf_full_cycles", 64'(perf_full_cycles), 64'(exp_full_cycles));
        check("perf_full_is_5", 64'(perf_full_cycles), 64'd5);
        check("perf_flushes", 64'(perf_flushes), 64'd2);
        @(posedge clk); #1;
`endif

        // Reset mid-operation drops everything
        id_ready = 1'b0;
        while (sb_q.size() < 2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 64'(id_valid), 64'd0);
        check("midrst_id_pc", 64'(id_pc), 64'd0);
        check("midrst_fetch_en", 64'(fetch_en), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
